parity_check_arbiter: RTL

//  Shares one registered 2xW-bit parity unit between two requesters, e.g. switch-entry path and test-sequence path.
//  Per job: round-robin grant, latch operands A/B, compute even parity BP = ^{A,B}.

---
 rtl/parity_arb_pkg.sv | 24 ++
 rtl/parity_xor_tree.sv | 17 +
 rtl/parity_check_arbiter.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/parity_arb_pkg.sv
// ----------------------------------------------------------------------------
// parity_arb_pkg
//   Shared definitions for the two-requester parity-check arbiter:
//   FSM state encodings, default widths and the round-robin pick helper.
// ----------------------------------------------------------------------------
package parity_arb_pkg;

    // Default operand width and error-counter width
    localparam int W_DEF        = 3;
    localparam int ERRCNT_W_DEF = 8;

    // FSM state encodings; 2'd3 is unused and recovers to IDLE
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    // Round-robin pick: returns 1 when requester 1 should be granted.
    // A lone requester always wins; on a tie, the one that was not
    // granted last time wins.
    function automatic logic rr_pick1(input logic v0, input logic v1, input logic last);
        return v1 & (~v0 | ~last);
    endfunction

endpackage

// File: rtl/parity_xor_tree.sv
// ----------------------------------------------------------------------------
// parity_xor_tree
//   Combinational even-parity reduction of an N-bit vector.
//   Ports:
//     in_i   [N-1:0]  bits to reduce
//     out_o           XOR of all bits of in_i
// ----------------------------------------------------------------------------
module parity_xor_tree #(
    parameter int N = 6
) (
    input  logic [N-1:0] in_i,
    output logic         out_o
);

    assign out_o = ^in_i;

endmodule

// File: rtl/parity_check_arbiter.sv
// ----------------------------------------------------------------------------
// parity_check_arbiter
//   Shares one registered 2xW-bit parity unit between two requesters.
//   Each job is granted round-robin, its operands latched, the parity
//   ^{A,B} registered and compared with the requester-supplied bit, and the
//   result offered over a valid/ready handshake. A saturating counter tracks
//   accepted results that flagged a mismatch.
//   Ports:
//     clk, rst                 clock, synchronous active-high reset
//     reqN_valid/a/b/pbit      job from requester N (N = 0, 1)
//     reqN_ready               job from requester N accepted this cycle
//     res_valid/res_ready      result handshake
//     res_id                   requester owning the result
//     res_parity               computed parity ^{A,B}
//     res_error                res_parity != expected parity bit
//     err_count                saturating count of accepted error results
//     busy                     FSM not in IDLE
// ----------------------------------------------------------------------------
module parity_check_arbiter
    import parity_arb_pkg::*;
#(
    parameter int W        = W_DEF,
    parameter int ERRCNT_W = ERRCNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req0_valid,
    input  logic [W-1:0]        req0_a,
    input  logic [W-1:0]        req0_b,
    input  logic                req0_pbit,
    output logic                req0_ready,
    input  logic                req1_valid,
    input  logic [W-1:0]        req1_a,
    input  logic [W-1:0]        req1_b,
    input  logic                req1_pbit,
    output logic                req1_ready,
    output logic                res_valid,
    input  logic                res_ready,
    output logic                res_id,
    output logic                res_parity,
    output logic                res_error,
    output logic [ERRCNT_W-1:0] err_count,
    output logic                busy
);

    // Saturating increment: all-ones stays all-ones
    function automatic logic [ERRCNT_W-1:0] sat_inc(input logic [ERRCNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + {{(ERRCNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic [1:0]          state_q, state_d;
    logic                last_grant_q;
    logic [W-1:0]        a_q, b_q;
    logic [W-1:0]        a_d, b_d;
    logic                pbit_q, pbit_d;
    logic                id_q;
    logic                parity_q;
    logic                error_q;
    logic [ERRCNT_W-1:0] err_cnt_q, err_cnt_d;

    logic                pick1;
    logic                accept;
    logic                xfer;
    logic                parity_w;

    assign pick1  = rr_pick1(req0_valid, req1_valid, last_grant_q);
    assign accept = req0_ready | req1_ready;
    assign xfer   = res_valid & res_ready;

    // Operand mux toward the latch, steered by the round-robin pick
    assign a_d    = pick1 ? req1_a    : req0_a;
    assign b_d    = pick1 ? req1_b    : req0_b;
    assign pbit_d = pick1 ? req1_pbit : req0_pbit;

    assign err_cnt_d = error_q ? sat_inc(err_cnt_q) : err_cnt_q;

    parity_xor_tree #(
        .N(2 * W)
    ) u_xor (
        .in_i  ({a_q, b_q}),
        .out_o (parity_w)
    );

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)    state_d = ST_CALC;
            ST_CALC:                state_d = ST_HOLD;
            ST_HOLD: if (res_ready) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Ready is only ever offered in IDLE and never while reset is asserted,
    // so a job presented during reset cannot be half-accepted.
    always_comb begin
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        res_valid  = 1'b0;
        busy       = 1'b1;
        case (state_q)
            ST_IDLE: begin
                busy = 1'b0;
                if (!rst) begin
                    req0_ready = req0_valid & ~pick1;
                    req1_ready = req1_valid &  pick1;
                end
            end
            ST_HOLD: res_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- operand, result and counter registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q          <= '0;
            b_q          <= '0;
            pbit_q       <= 1'b0;
            id_q         <= 1'b0;
            parity_q     <= 1'b0;
            error_q      <= 1'b0;
            last_grant_q <= 1'b1;   // requester 0 wins the first tie
            err_cnt_q    <= '0;
        end else begin
            if (accept) begin
                a_q    <= a_d;
                b_q    <= b_d;
                pbit_q <= pbit_d;
                id_q   <= pick1;
            end
            if (state_q == ST_CALC) begin
                parity_q <= parity_w;
                error_q  <= parity_w ^ pbit_q;
            end
            // Pointer and counter move only when the consumer takes the result
            if (xfer) begin
                last_grant_q <= id_q;
                err_cnt_q    <= err_cnt_d;
            end
        end
    end

    assign res_id     = id_q;
    assign res_parity = parity_q;
    assign res_error  = error_q;
    assign err_count  = err_cnt_q;

endmodule
